// File: rtl/excess3_collector.sv
// Serial excess-3 bit collector: packs LSB-first bits into 4-bit digits
// and buffers them in a FIFO drained by a valid/ready handshake.
//
// Optional feature macro: EXCESS3_CHECK_EN
//   defined   : each completed digit tagged ovf=0 is range-checked
//               (4'b0011..4'b1100); violations set sticky code_err
//   undefined : no checker logic, code_err tied low
//
// Ports:
//   clk          system clock, all flops on rising edge
//   reset_n      synchronous active-low reset
//   bit_valid    serial bit present on s_in/v_in
//   s_in         serial excess-3 sum bit, LSB first
//   v_in         converter overflow flag (captured with bit 3 only)
//   align        force digit boundary, discard partial bits
//   digit_out    FIFO head digit {b3,b2,b1,b0}, 0 when empty
//   digit_ovf    overflow tag of head digit, 0 when empty
//   digit_valid  FIFO not empty
//   digit_ready  consumer accepts head this cycle
//   overrun      sticky: completed digit dropped on full FIFO
//   code_err     sticky: invalid excess-3 code seen
module excess3_collector #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       bit_valid,
  input  logic       s_in,
  input  logic       v_in,
  input  logic       align,
  output logic [3:0] digit_out,
  output logic       digit_ovf,
  output logic       digit_valid,
  input  logic       digit_ready,
  output logic       overrun,
  output logic       code_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] COLLECT0 = 2'd0;
  localparam logic [1:0] COLLECT1 = 2'd1;
  localparam logic [1:0] COLLECT2 = 2'd2;
  localparam logic [1:0] COLLECT3 = 2'd3;

  // ------------------------------------------------------------
  // Bit collection
  // ------------------------------------------------------------
  logic [1:0] r_cnt;
  logic [2:0] r_shift;

  logic       w_take;
  logic       w_done;
  logic [3:0] w_digit;
  logic       w_tag;

  // align wins over a coincident bit_valid
  assign w_take  = bit_valid & ~align;
  assign w_done  = w_take & (r_cnt == COLLECT3);
  // bit 3 comes straight from s_in; the digit is pushed on this edge
  assign w_digit = {s_in, r_shift};
  assign w_tag   = v_in;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt   <= COLLECT0;
      r_shift <= 3'b000;
    end else if (align) begin
      r_cnt   <= COLLECT0;
      r_shift <= 3'b000;
    end else if (bit_valid) begin
      unique case (r_cnt)
        COLLECT0: begin
          r_shift[0] <= s_in;
          r_cnt      <= COLLECT1;
        end
        COLLECT1: begin
          r_shift[1] <= s_in;
          r_cnt      <= COLLECT2;
        end
        COLLECT2: begin
          r_shift[2] <= s_in;
          r_cnt      <= COLLECT3;
        end
        COLLECT3: begin
          r_shift <= 3'b000;
          r_cnt   <= COLLECT0;
        end
        default: begin
          r_shift <= 3'b000;
          r_cnt   <= COLLECT0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------
  // Digit FIFO
  // ------------------------------------------------------------
  logic [4:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_overrun;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = ~w_empty & digit_ready;
  // a pop on the same edge frees the slot for a full-FIFO push
  assign w_push  = w_done & (~w_full | w_pop);
  assign w_drop  = w_done & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {w_tag, w_digit};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  logic [4:0] w_head;

  // memory is not reset; gate the head so an empty FIFO reads as 0
  assign w_head      = w_empty ? 5'd0 : r_mem[r_rptr];
  assign digit_out   = w_head[3:0];
  assign digit_ovf   = w_head[4];
  assign digit_valid = ~w_empty;
  assign overrun     = r_overrun;

  // ------------------------------------------------------------
  // Optional excess-3 code checker
  // ------------------------------------------------------------
`ifdef EXCESS3_CHECK_EN
  logic r_code_err;
  logic w_bad;

  // checked on every completed digit, even one that gets dropped
  assign w_bad = w_done & ~w_tag &
                 ((w_digit < 4'd3) | (w_digit > 4'd12));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_code_err <= 1'b0;
    end else if (w_bad) begin
      r_code_err <= 1'b1;
    end
  end

  assign code_err = r_code_err;
`else
  assign code_err = 1'b0;
`endif

endmodule

// File: tb/tb_excess3_collector.sv
// Bench for excess3_collector: table vectors, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_excess3_collector;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       bit_valid;
  logic       s_in;
  logic       v_in;
  logic       align;
  logic [3:0] digit_out;
  logic       digit_ovf;
  logic       digit_valid;
  logic       digit_ready;
  logic       overrun;
  logic       code_err;

  excess3_collector #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bit_valid  (bit_valid),
    .s_in       (s_in),
    .v_in       (v_in),
    .align      (align),
    .digit_out  (digit_out),
    .digit_ovf  (digit_ovf),
    .digit_valid(digit_valid),
    .digit_ready(digit_ready),
    .overrun    (overrun),
    .code_err   (code_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(string nm, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t",
                  nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int m_q[$];     // entries: ovf*16 + digit
  int m_bits[$];
  bit m_ovr;
  bit m_err;

  task automatic model(bit rst, bit bv, bit s, bit v,
                       bit al, bit rdy);
    bit pop;
    bit full;
    int d;
    if (rst) begin
      m_q.delete();
      m_bits.delete();
      m_ovr = 0;
      m_err = 0;
      return;
    end
    pop  = (m_q.size() > 0) && rdy;
    full = (m_q.size() >= DEPTH);
    if (pop) void'(m_q.pop_front());
    if (al) m_bits.delete();
    else if (bv) begin
      m_bits.push_back(int'(s));
      if (m_bits.size() == 4) begin
        d = m_bits[0] + 2*m_bits[1] + 4*m_bits[2] + 8*m_bits[3];
        m_bits.delete();
        if (!full || pop) m_q.push_back(d + (v ? 16 : 0));
        else m_ovr = 1;
`ifdef EXCESS3_CHECK_EN
        if (!v && (d < 3 || d > 12)) m_err = 1;
`endif
      end
    end
  endtask

  task automatic cmp_model();
    chk("valid", int'(digit_valid), int'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("digit", int'(digit_out), m_q[0] % 16);
      chk("ovf", int'(digit_ovf), m_q[0] / 16);
    end
    chk("overrun", int'(overrun), int'(m_ovr));
    chk("code_err", int'(code_err), int'(m_err));
  endtask

  task automatic step(bit rst, bit bv, bit s, bit v,
                      bit al, bit rdy);
    reset_n     = !rst;
    bit_valid   = bv;
    s_in        = s;
    v_in        = v;
    align       = al;
    digit_ready = rdy;
    @(posedge clk);
    model(rst, bv, s, v, al, rdy);
    #1;
    cmp_model();
  endtask

  task automatic send(int d, bit v3, bit rdy_last);
    for (int k = 0; k < 4; k++)
      step(0, 1, d[k], (k == 3) ? v3 : 1'b0, 0,
           (k == 3) ? rdy_last : 1'b0);
  endtask

  task automatic pop1();
    step(0, 0, 0, 0, 0, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit rst, bv, s, v, al, rdy;
    bit ev;
    int eo;
    bit ef;
    bit er;
  } vec_t;

  vec_t tbl[27];

  function automatic vec_t mk(bit rst, bit bv, bit s, bit v, bit al,
                              bit rdy, bit ev, int eo, bit ef, bit er);
    vec_t t;
    t.rst = rst; t.bv = bv; t.s = s; t.v = v; t.al = al; t.rdy = rdy;
    t.ev = ev; t.eo = eo; t.ef = ef; t.er = er;
    return t;
  endfunction

  initial begin
    tbl[0]  = mk(1,0,0,0,0,0, 0,0,0,0);
    tbl[1]  = mk(0,1,0,0,0,0, 0,0,0,0);
    tbl[2]  = mk(0,1,0,0,0,0, 0,0,0,0);
    tbl[3]  = mk(0,1,0,0,0,0, 0,0,0,0);
    tbl[4]  = mk(0,1,1,0,0,0, 1,8,0,0);
    tbl[5]  = mk(0,0,0,0,0,1, 0,0,0,0);
    tbl[6]  = mk(0,1,1,1,0,0, 0,0,0,0);
    tbl[7]  = mk(0,1,0,1,0,0, 0,0,0,0);
    tbl[8]  = mk(0,1,1,1,0,0, 0,0,0,0);
    tbl[9]  = mk(0,1,0,0,0,0, 1,5,0,0);
    tbl[10] = mk(0,0,0,0,0,1, 0,0,0,0);
    tbl[11] = mk(0,1,1,0,0,0, 0,0,0,0);
    tbl[12] = mk(0,1,1,0,0,0, 0,0,0,0);
    tbl[13] = mk(0,1,1,0,1,0, 0,0,0,0);
    tbl[14] = mk(0,1,1,0,0,0, 0,0,0,0);
    tbl[15] = mk(0,1,0,0,0,0, 0,0,0,0);
    tbl[16] = mk(0,1,1,0,0,0, 0,0,0,0);
    tbl[17] = mk(0,1,0,1,0,0, 1,5,1,0);
    tbl[18] = mk(0,0,0,0,0,1, 0,0,0,0);
    tbl[19] = mk(0,1,1,0,0,0, 0,0,0,0);
    tbl[20] = mk(0,1,1,0,0,0, 0,0,0,0);
    tbl[21] = mk(1,0,0,0,0,0, 0,0,0,0);
    tbl[22] = mk(0,1,1,0,0,0, 0,0,0,0);
    tbl[23] = mk(0,1,1,0,0,0, 0,0,0,0);
    tbl[24] = mk(0,1,0,0,0,0, 0,0,0,0);
    tbl[25] = mk(0,1,0,0,0,0, 1,3,0,0);
    tbl[26] = mk(0,0,0,0,0,1, 0,0,0,0);

    reset_n = 0; bit_valid = 0; s_in = 0; v_in = 0;
    align = 0; digit_ready = 0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 27; i++) begin
      step(tbl[i].rst, tbl[i].bv, tbl[i].s, tbl[i].v,
           tbl[i].al, tbl[i].rdy);
      chk($sformatf("t%0d_valid", i), int'(digit_valid),
          int'(tbl[i].ev));
      if (tbl[i].ev || tbl[i].rst) begin
        chk($sformatf("t%0d_out", i), int'(digit_out), tbl[i].eo);
        chk($sformatf("t%0d_ovf", i), int'(digit_ovf),
            int'(tbl[i].ef));
      end
      chk($sformatf("t%0d_ovr", i), int'(overrun), int'(tbl[i].er));
    end

    // full FIFO, fifth digit dropped
    step(1, 0, 0, 0, 0, 0);
    send(3, 0, 0); send(5, 0, 0); send(7, 0, 0); send(9, 0, 0);
    chk("full_valid", int'(digit_valid), 1);
    chk("full_noovr", int'(overrun), 0);
    send(12, 0, 0);
    chk("drop_ovr", int'(overrun), 1);
    chk("head3", int'(digit_out), 3); pop1();
    chk("head5", int'(digit_out), 5); pop1();
    chk("head7", int'(digit_out), 7); pop1();
    chk("head9", int'(digit_out), 9); pop1();
    chk("drained", int'(digit_valid), 0);
    chk("ovr_sticky", int'(overrun), 1);

    // full FIFO, fifth digit completes with a pop
    step(1, 0, 0, 0, 0, 0);
    send(3, 0, 0); send(5, 0, 0); send(7, 0, 0); send(9, 0, 0);
    send(12, 0, 1);
    chk("sim_noovr", int'(overrun), 0);
    chk("sim_head5", int'(digit_out), 5); pop1();
    chk("sim_head7", int'(digit_out), 7); pop1();
    chk("sim_head9", int'(digit_out), 9); pop1();
    chk("sim_head12", int'(digit_out), 12); pop1();
    chk("sim_empty", int'(digit_valid), 0);

    // push into empty FIFO while ready is high: no bypass
    send(6, 1, 1);
    chk("nobyp_valid", int'(digit_valid), 1);
    chk("nobyp_out", int'(digit_out), 6);
    chk("nobyp_ovf", int'(digit_ovf), 1);
    pop1();

    // invalid code
    send(0, 0, 0);
`ifdef EXCESS3_CHECK_EN
    chk("cerr_set", int'(code_err), 1);
`else
    chk("cerr_off", int'(code_err), 0);
`endif
    pop1();
    send(4, 0, 1);
    pop1();
`ifdef EXCESS3_CHECK_EN
    chk("cerr_sticky", int'(code_err), 1);
`else
    chk("cerr_off2", int'(code_err), 0);
`endif
    send(15, 1, 0);
    pop1();

    // randomized traffic
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 8),
           1'($urandom),
           1'($urandom),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 9) < ((i / 500) % 2 ? 2 : 6)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
